key_load_ctrl: RTL

//  Sequences loading of the cipher key register from the incoming byte stream.
//  - Sits between the byte receiver and the key register.
//  - Detects the key-load command byte, clears the key register, then issues one kset strobe per key byte.
//  - Guards the transfer with an inter-byte timeout, then flags keys_ready to the cipher datapath.

---
 rtl/yoda_pkg.sv | 23 ++
 rtl/key_timeout_cnt.sv | 30 +++
 rtl/key_load_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/yoda_pkg.sv
// Shared definitions for the key-load and cipher controllers: load FSM states,
// command byte and default load geometry.
package yoda_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int unsigned DEF_NUM_KEY_BYTES  = 4;
    localparam logic [7:0]  DEF_CMD_KEY        = 8'h4B;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000;
    localparam int unsigned DEF_TO_W           = 20;

    // XOR-fold step used for the optional key checksum.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/key_timeout_cnt.sv
// Inter-byte timeout counter: cleared on clr, counts while en, and parks at
// TIMEOUT_CYCLES-1 where expired is raised.
module key_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned TO_W           = 20
) (
    input  logic dclk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] count;

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/key_load_ctrl.sv
// Key-load sequencer: detects CMD_KEY, clears the key register, strobes kset per
// key byte, guards with an inter-byte timeout. Optional checksum byte: KEY_CHECKSUM_EN.
module key_load_ctrl
    import yoda_pkg::*;
#(
    parameter int unsigned NUM_KEY_BYTES  = DEF_NUM_KEY_BYTES,
    parameter logic [7:0]  CMD_KEY        = DEF_CMD_KEY,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEF_TO_W
) (
    input  logic       dclk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] key_din,
    output logic       kset,
    output logic       key_clr,
    output logic [2:0] key_cnt,
    output logic       keys_ready,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_csum
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_KEY_BYTES - 1);
    localparam logic [2:0] MAX_CNT  = 3'(NUM_KEY_BYTES);

    state_t state, state_nxt;
    logic   accept;
    logic   is_cmd;
    logic   to_clr, to_en, to_expired;

`ifdef KEY_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_ok;
    assign csum_ok = (rx_data == csum);
`endif

    // rx_ready is a pure function of state so accept carries no combinational loop.
    assign rx_ready = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_CHECK);
    assign busy     = (state == ST_CLEAR) || (state == ST_LOAD) || (state == ST_CHECK);
    assign accept   = rx_valid && rx_ready;
    assign is_cmd   = (rx_data == CMD_KEY);

    key_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .dclk   (dclk),
        .reset  (reset),
        .clr    (to_clr),
        .en     (to_en),
        .expired(to_expired)
    );

    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        to_clr    = 1'b1;
        to_en     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (accept && is_cmd) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                to_clr = accept;
                to_en  = !accept;
                if (accept) begin
                    if (key_cnt == LAST_IDX) begin
`ifdef KEY_CHECKSUM_EN
                        state_nxt = ST_CHECK;
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end else if (to_expired) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
`ifdef KEY_CHECKSUM_EN
                to_clr = accept;
                to_en  = !accept;
                if (accept) begin
                    state_nxt = csum_ok ? ST_DONE : ST_IDLE;
                end else if (to_expired) begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Strobes are registered and default low, so they never glitch out of reset.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            key_din     <= '0;
            kset        <= 1'b0;
            key_clr     <= 1'b0;
            key_cnt     <= '0;
            keys_ready  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            kset    <= 1'b0;
            key_clr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept && is_cmd) begin
                        key_clr     <= 1'b1;
                        keys_ready  <= 1'b0;
                        err_timeout <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    key_cnt <= '0;
                end
                ST_LOAD: begin
                    if (accept) begin
                        key_din <= rx_data;
                        kset    <= 1'b1;
                        if (key_cnt != MAX_CNT) key_cnt <= key_cnt + 1'b1;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                    end
                end
                ST_CHECK: begin
`ifdef KEY_CHECKSUM_EN
                    if (accept) begin
                        if (!csum_ok) key_clr <= 1'b1;
                    end else if (to_expired) begin
                        err_timeout <= 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    keys_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef KEY_CHECKSUM_EN
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            csum     <= '0;
            err_csum <= 1'b0;
        end else begin
            if (state == ST_IDLE && accept && is_cmd) err_csum <= 1'b0;
            if (state == ST_CLEAR) csum <= '0;
            if (state == ST_LOAD && accept) csum <= csum_step(csum, rx_data);
            if (state == ST_CHECK && accept && !csum_ok) err_csum <= 1'b1;
        end
    end
`else
    assign err_csum = 1'b0;
`endif

endmodule
